rv32_lsu: RTL and testbench
===========================

# rv32_lsu

Load/store unit that sits between the RV32I execute stage and the variable-latency data memory, acting as that memory's initiator. Accepts one load or store at a time from the core, checks alignment and range, and drives the memory's MemRead/MemWrite/MemSize handshake. Waits for Ready, sign- or zero-extends load data per funct3, and returns a single-cycle response with an error flag.

## Interface
- MEM_BYTES, 2048: size of the data memory; byte addresses ≥ MEM_BYTES fault.
- TIMEOUT, 15: maximum cycles spent waiting for Ready before a load faults.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request strobe.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_err  out  1  misaligned, out-of-range, timeout, or illegal funct3.
- MemRead  out  1  memory read request, held until Ready is sampled.
- MemWrite  out  1  memory write strobe, one cycle.
- MemSize  out  2  00 byte, 01 halfword, 10 word.
- address  out  32  byte address to memory.
- write_data  out  32  store data passed unchanged.
- data_out  in  32  memory read data, zero-extended and right-aligned.
- Ready  in  1  memory read-data-valid pulse.

## Operation
- States: IDLE, RD_WAIT, WR, FAULT.
- IDLE:
  - Request accepted on an edge where req_valid is high; req_ready is 1 in IDLE.
  - address, MemSize and write_data are registered from the request.
  - Misaligned, ≥ MEM_BYTES, or illegal funct3 → FAULT, no memory strobe.
  - Otherwise a load → RD_WAIT with MemRead=1, and a store → WR with MemWrite=1.
- Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value other than 000, 001, 010.
- WR: MemWrite high for exactly one cycle, then → IDLE with resp_valid=1, resp_err=0.
- RD_WAIT:
  - MemRead held and wait counter incremented each cycle.
  - Ready=1 → capture data_out and extend it: LB from bit 7, LH from bit 15, LBU/LHU zero-extended, LW unchanged.
  - On Ready, MemRead is cleared, resp_valid=1 is issued and the state returns to IDLE.
  - Counter reaching TIMEOUT without Ready → MemRead cleared, resp_err=1, resp_rdata=0, → IDLE.
- FAULT: resp_valid=1, resp_err=1, resp_rdata=0 for one cycle, → IDLE.
- The RD_WAIT→IDLE transition guarantees MemRead is low for at least one cycle between loads, which re-arms the memory's latency counter.
- A Ready arriving outside RD_WAIT is ignored.
- Request inputs are ignored while req_ready is 0.
- Reset, including mid-transaction, forces the following, and no response is issued for the aborted transaction:
  - State IDLE; req_ready becomes 1 once reset deasserts.
  - MemRead, MemWrite, resp_valid and resp_err = 0.
  - MemSize, address, write_data and resp_rdata = 0.
  - Wait counter cleared.

## Timing
- All outputs are registered; there is no combinational path from the memory inputs to any output.
- Store: MemWrite is high in the cycle after the accept edge, and resp_valid is high one cycle later.
- Load, measured with edge E0 as the accept edge:
  - Memory at 0x000–0x3FF → Ready high after E2, resp_valid high after E3.
  - Memory at 0x400–0x5FF → resp_valid high after E4.
  - Memory at 0x600–0x7FF → resp_valid high after E5.
- Fault: resp_valid high in the cycle after the accept edge.
- Back-to-back: a new request can be accepted on the edge following the resp_valid edge (throughput of one outstanding request).

## Structure
- The package rv32_lsu_pkg holds:
  - funct3 constants.
  - MemSize encodings SZ_BYTE / SZ_HALF / SZ_WORD.
  - State enum.
- Sub-module rv32_load_ext: combinational funct3-driven sign/zero extension, reusable by the writeback stage.

## Test plan
- SW 0xDEADBEEF to 0x010, then LW 0x010:
  - MemWrite pulses one cycle.
  - Load resp_rdata=0xDEADBEEF, resp_err=0.
  - resp_valid 3 edges after accept.
- SB 0x80 to 0x413, then LB and LBU at 0x413:
  - LB gives 0xFFFFFF80, LBU gives 0x00000080.
  - resp_valid 4 edges after accept.
- SH 0x8001 to 0x602, then LH and LHU at 0x602:
  - LH gives 0xFFFF8001, LHU gives 0x00008001.
  - resp_valid 5 edges after accept.
- Misaligned and out-of-range requests: LW 0x002, SH 0x005, LW 0x800.
  - Each gives resp_err=1 one cycle after accept.
  - MemRead and MemWrite are never asserted.
- Memory model that never raises Ready → resp_err=1, resp_rdata=0 after TIMEOUT cycles, with MemRead then low.
- rst asserted two cycles into a slow LW:
  - All outputs 0 immediately; no resp_valid.
  - A following LW completes normally.

Source files
------------

// File: rtl/rv32_lsu_pkg.sv
// rv32_lsu_pkg: shared funct3/MemSize encodings, FSM states and request checks for the LSU.
package rv32_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_WR,
        S_FAULT
    } state_e;

    // Stores only allow B/H/W; loads additionally allow the unsigned B/H forms.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return we ? (f3[2] || f3[1:0] == 2'b11) : (f3[1:0] == 2'b11 || f3 == 3'b110);
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00);
    endfunction

endpackage

// File: rtl/rv32_lsu_if.sv
// rv32_lsu_if: data-memory handshake bus; the LSU is master, the memory is slave.
interface rv32_lsu_if;

    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] data_out;
    logic        Ready;

    modport master (
        output MemRead, MemWrite, MemSize, address, write_data,
        input  data_out, Ready
    );

    modport slave (
        input  MemRead, MemWrite, MemSize, address, write_data,
        output data_out, Ready
    );

endinterface

// File: rtl/rv32_load_ext.sv
// rv32_load_ext: funct3-driven sign/zero extension of right-aligned load data.
module rv32_load_ext
    import rv32_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = funct3_i == F3_B  ? {{24{data_i[7]}}, data_i[7:0]}   :
                 funct3_i == F3_H  ? {{16{data_i[15]}}, data_i[15:0]} :
                 funct3_i == F3_W  ? data_i                           :
                 funct3_i == F3_BU ? {24'h0, data_i[7:0]}             :
                 funct3_i == F3_HU ? {16'h0, data_i[15:0]}            : 32'h0;
    end

endmodule

// File: rtl/rv32_lsu.sv
// rv32_lsu: single-outstanding load/store unit between execute and a variable-latency data memory.
module rv32_lsu
    import rv32_lsu_pkg::*;
#(
    parameter int MEM_BYTES = 2048,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    rv32_lsu_if.master  mem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic          rdy_q, rdy_d, rd_q, rd_d, wr_q, wr_d, rv_q, rv_d, err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    size_q, size_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, ext_data;
    logic          bad;

    assign bad = f3_illegal(req_we, req_funct3) || misaligned(req_funct3[1:0], req_addr[1:0]) ||
                 req_addr >= 32'(MEM_BYTES);

    rv32_load_ext u_ext (
        .funct3_i (f3_q),
        .data_i   (mem.data_out),
        .data_o   (ext_data)
    );

    // Faults respond straight from the accept edge; FAULT is the cycle that response is visible.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        wr_d    = 1'b0;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rv_d    = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        unique case (state_q)
            S_IDLE: if (req_valid && rdy_q) begin
                f3_d    = req_funct3;
                size_d  = req_funct3[1:0];
                addr_d  = req_addr;
                wdata_d = req_wdata;
                cnt_d   = '0;
                rd_d    = !bad && !req_we;
                wr_d    = !bad && req_we;
                rv_d    = bad;
                err_d   = bad;
                state_d = bad ? S_FAULT : req_we ? S_WR : S_RD_WAIT;
            end
            S_RD_WAIT: if (mem.Ready) begin
                rd_d    = 1'b0;
                rv_d    = 1'b1;
                rdata_d = ext_data;
                state_d = S_IDLE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                rd_d    = 1'b0;
                rv_d    = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            S_WR: begin
                rv_d    = 1'b1;
                state_d = S_IDLE;
            end
            S_FAULT: state_d = S_IDLE;
        endcase
        rdy_d = state_d == S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
            f3_q    <= 3'h0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= 2'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign req_ready      = rdy_q;
    assign resp_valid     = rv_q;
    assign resp_err       = err_q;
    assign resp_rdata     = rdata_q;
    assign mem.MemRead    = rd_q;
    assign mem.MemWrite   = wr_q;
    assign mem.MemSize    = size_q;
    assign mem.address    = addr_q;
    assign mem.write_data = wdata_q;

endmodule

// File: tb/tb_rv32_lsu.sv
// tb_rv32_lsu: directed bench with a byte-array reference model, latency-banded memory and per-cycle compare.
module tb_rv32_lsu;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_ready;
    logic [2:0]  req_funct3 = 3'h0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;

    rv32_lsu_if mif ();

    rv32_lsu #(.MEM_BYTES(2048), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, mcnt = 0;
    bit dead = 1'b0;
    logic [7:0] dev [2048] = '{default: 8'h0};
    logic [7:0] sh  [2048] = '{default: 8'h0};

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];
    int rd_lo = -1, rd_hi = -2, wr_at = -1;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0;
    logic [1:0]  e_size = 2'h0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic int region_lat(input logic [31:0] a);
        return a < 32'h400 ? 3 : a < 32'h600 ? 4 : 5;
    endfunction

    // Reference model: decides fault/store/load outcome and response edge at the accept edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst && req_valid && req_ready) begin
            int n, lat;
            longint v;
            logic f;
            n = 1 << req_funct3[1:0];
            f = (req_we ? req_funct3 > 3'd2 : req_funct3 inside {3'd3, 3'd6, 3'd7}) ||
                (n == 2 && req_addr % 2 != 0) || (n >= 4 && req_addr % 4 != 0) || req_addr >= 2048;
            e_addr  = req_addr;
            e_size  = req_funct3[1:0];
            e_wdata = req_wdata;
            if (f) begin
                q.push_back('{cyc, 1'b1, 32'h0});
            end else if (req_we) begin
                for (int i = 0; i < n; i++) sh[req_addr + i] = req_wdata[8*i +: 8];
                wr_at = cyc;
                q.push_back('{cyc + 1, 1'b0, 32'h0});
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v += longint'(sh[req_addr + i]) << (8 * i);
                if (!req_funct3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
                lat   = dead ? TIMEOUT : region_lat(req_addr);
                rd_lo = cyc;
                rd_hi = cyc + lat - 1;
                q.push_back('{cyc + lat, dead, dead ? 32'h0 : v[31:0]});
            end
        end
    end

    // Memory: Ready pulses lat-1 edges after MemRead rises; MemRead must drop to re-arm.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt = 0;
            mif.Ready    <= 1'b0;
            mif.data_out <= 32'h0;
        end else begin
            logic [31:0] d;
            mif.Ready <= 1'b0;
            if (mif.MemWrite)
                for (int i = 0; i < (1 << mif.MemSize); i++) dev[mif.address + i] = mif.write_data[8*i +: 8];
            if (!mif.MemRead) begin
                mcnt = 0;
            end else if (!dead && mcnt >= 0) begin
                mcnt++;
                if (mcnt == region_lat(mif.address) - 1) begin
                    d = 32'h0;
                    for (int i = 0; i < (1 << mif.MemSize); i++) d[8*i +: 8] = dev[mif.address + i];
                    mif.Ready    <= 1'b1;
                    mif.data_out <= d;
                    mcnt = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_err", resp_err, 0);
            chk("rst_resp_rdata", resp_rdata, 0);
            chk("rst_MemRead", mif.MemRead, 0);
            chk("rst_MemWrite", mif.MemWrite, 0);
            chk("rst_MemSize", mif.MemSize, 0);
            chk("rst_address", mif.address, 0);
            chk("rst_write_data", mif.write_data, 0);
            q.delete();
            rd_hi = -2;
            wr_at = -1;
        end else begin
            logic ev;
            ev = q.size() > 0 && q[0].due == cyc;
            chk("resp_valid", resp_valid, ev);
            if (ev) begin
                chk("resp_err", resp_err, q[0].err);
                chk("resp_rdata", resp_rdata, q[0].rdata);
                void'(q.pop_front());
            end
            chk("MemRead", mif.MemRead, cyc >= rd_lo && cyc <= rd_hi);
            chk("MemWrite", mif.MemWrite, cyc == wr_at);
            if (mif.MemRead || mif.MemWrite) begin
                chk("address", mif.address, e_addr);
                chk("MemSize", mif.MemSize, e_size);
            end
            if (mif.MemWrite) chk("write_data", mif.write_data, e_wdata);
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic e, output int lat);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        chk("accept_seen", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin @(posedge clk); #1; n++; end
        chk("resp_seen", resp_valid, 1);
        rd = resp_rdata; e = resp_err; lat = n;
    endtask

    task automatic run(input string nm, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] x_rd, input logic x_e, input int x_lat);
        logic [31:0] rd;
        logic e;
        int lat;
        do_req(we, f3, a, wd, rd, e, lat);
        chk({nm, "_rdata"}, rd, x_rd);
        chk({nm, "_err"}, e, x_e);
        chk({nm, "_lat"}, lat, x_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        run("sw",   1, 3'b010, 32'h010, 32'hDEADBEEF, 32'h0,        0, 1);
        run("lw",   0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 0, 3);
        run("sb",   1, 3'b000, 32'h413, 32'h12345680, 32'h0,        0, 1);
        run("lb",   0, 3'b000, 32'h413, 32'h0,        32'hFFFFFF80, 0, 4);
        run("lbu",  0, 3'b100, 32'h413, 32'h0,        32'h00000080, 0, 4);
        run("sh",   1, 3'b001, 32'h602, 32'hABCD8001, 32'h0,        0, 1);
        run("lh",   0, 3'b001, 32'h602, 32'h0,        32'hFFFF8001, 0, 5);
        run("lhu",  0, 3'b101, 32'h602, 32'h0,        32'h00008001, 0, 5);
        run("lw_mis",  0, 3'b010, 32'h002, 32'h0, 32'h0, 1, 0);
        run("sh_mis",  1, 3'b001, 32'h005, 32'h1, 32'h0, 1, 0);
        run("lw_oor",  0, 3'b010, 32'h800, 32'h0, 32'h0, 1, 0);
        run("ld_f3",   0, 3'b011, 32'h020, 32'h0, 32'h0, 1, 0);
        run("st_f3",   1, 3'b100, 32'h020, 32'h5, 32'h0, 1, 0);
        run("lw_edge", 0, 3'b010, 32'h7FC, 32'h0, 32'h0, 0, 5);
        dead = 1'b1;
        run("lw_tmo",  0, 3'b010, 32'h010, 32'h0, 32'h0, 1, TIMEOUT);
        dead = 1'b0;
        chk("tmo_MemRead_low", mif.MemRead, 0);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_MemRead", mif.MemRead, 1);
        rst = 1'b1;
        #1;
        chk("arst_MemRead", mif.MemRead, 0);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_address", mif.address, 0);
        chk("arst_MemSize", mif.MemSize, 0);
        chk("arst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        run("lw_post_rst", 0, 3'b010, 32'h010, 32'h0, 32'hDEADBEEF, 0, 3);
        repeat (3) @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
